// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, field positions and default local credit depth.
package noc_pkg;

    localparam int unsigned NOC_FLIT_W          = 20;
    localparam int unsigned NOC_DEST_CLU_MSB    = 19;
    localparam int unsigned NOC_DEST_CLU_LSB    = 18;
    localparam int unsigned NOC_DEST_LOC_MSB    = 17;
    localparam int unsigned NOC_DEST_LOC_LSB    = 16;
    localparam int unsigned NOC_PAYLOAD_MSB     = 15;
    localparam int unsigned NOC_PAYLOAD_LSB     = 0;
    localparam int unsigned NOC_DEFAULT_CREDITS = 4;

    typedef struct packed {
        logic [1:0]  dest_cluster;
        logic [1:0]  dest_local;
        logic [15:0] payload;
    } flit_t;

    function automatic logic [NOC_FLIT_W-1:0] make_flit(input logic [1:0]  clu,
                                                        input logic [1:0]  loc,
                                                        input logic [15:0] payload);
        return {clu, loc, payload};
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO with registered storage; push when full and pop when empty are ignored.
module ni_fifo #(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ni_inject_queue.sv
// PE-to-router injection queue with credit-based flow control toward the router local input.
// Define NI_STATS_EN to add saturating stat_sent / stat_stall counters.
module ni_inject_queue
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W  = NOC_FLIT_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CREDITS = NOC_DEFAULT_CREDITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        pe_flit,
    input  logic                     pe_valid,
    output logic                     pe_ready,
    output logic [FLIT_W-1:0]        rt_flit,
    output logic                     rt_valid,
    input  logic                     rt_credit,
    output logic                     cred_err,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef NI_STATS_EN
    ,
    output logic [15:0]              stat_sent,
    output logic [15:0]              stat_stall
`endif
);

    localparam int unsigned CW = $clog2(CREDITS + 1);

    logic [CW-1:0]     credit;
    logic [CW-1:0]     credit_nxt;
    logic              cred_err_nxt;
    logic              empty;
    logic              full;
    logic              send;
    logic [FLIT_W-1:0] head;

    assign send     = !empty && (credit != '0);
    assign rt_valid = send;
    assign pe_ready = !full;
    assign rt_flit  = empty ? '0 : head;

    ni_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pe_valid),
        .din   (pe_flit),
        .pop   (send),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // A send and a returned credit in the same cycle cancel; a surplus credit saturates and flags
    always_comb begin
        credit_nxt   = credit;
        cred_err_nxt = cred_err;
        case ({send, rt_credit})
            2'b10: credit_nxt = credit - CW'(1);
            2'b01: begin
                if (credit == CW'(CREDITS)) begin
                    cred_err_nxt = 1'b1;
                end else begin
                    credit_nxt = credit + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit   <= CW'(CREDITS);
            cred_err <= 1'b0;
        end else begin
            credit   <= credit_nxt;
            cred_err <= cred_err_nxt;
        end
    end

`ifdef NI_STATS_EN
    logic stall;

    assign stall = !empty && (credit == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_sent  <= '0;
            stat_stall <= '0;
        end else begin
            if (send && (stat_sent != 16'hFFFF)) begin
                stat_sent <= stat_sent + 16'd1;
            end
            if (stall && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ni_inject_queue.sv
// Directed bench for ni_inject_queue: reset, latency, credit stalls, full queue, credit errors.
module tb_ni_inject_queue;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic [19:0] pe_flit   = '0;
    logic        pe_valid  = 1'b0;
    logic        pe_ready;
    logic [19:0] rt_flit;
    logic        rt_valid;
    logic        rt_credit = 1'b0;
    logic        cred_err;
    logic [2:0]  occupancy;
`ifdef NI_STATS_EN
    logic [15:0] stat_sent;
    logic [15:0] stat_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] rx_q [$];
    logic [19:0] f3 [6];
    logic [19:0] g5 [5];

    ni_inject_queue #(
        .FLIT_W  (20),
        .DEPTH   (4),
        .CREDITS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pe_flit   (pe_flit),
        .pe_valid  (pe_valid),
        .pe_ready  (pe_ready),
        .rt_flit   (rt_flit),
        .rt_valid  (rt_valid),
        .rt_credit (rt_credit),
        .cred_err  (cred_err),
        .occupancy (occupancy)
`ifdef NI_STATS_EN
        ,
        .stat_sent  (stat_sent),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; whatever is offered to the router in the new cycle will be taken
    task automatic step();
        @(posedge clk);
        #1;
        if (rt_valid) rx_q.push_back(rt_flit);
    endtask

    initial begin
        f3 = '{20'hC0F00, 20'hC0F01, 20'h4ABCD, 20'h81234, 20'h3FFFF, 20'h00001};
        g5 = '{20'h1AAAA, 20'h2BBBB, 20'h3CCCC, 20'h4DDDD, 20'h5EEEE};

        // T1 reset
        #1;
        check("t1_ready", pe_ready, 1);
        check("t1_valid", rt_valid, 0);
        check("t1_occ", occupancy, 0);
        check("t1_err", cred_err, 0);
        check("t1_flit", rt_flit, 0);
        step();
        rst = 1'b1;
        step();
        step();
        check("t1_idle_valid", rt_valid, 0);
        check("t1_idle_occ", occupancy, 0);
        check("t1_idle_ready", pe_ready, 1);

        // T2 single flit, latency 1
        pe_flit  = 20'hA1234;
        pe_valid = 1'b1;
        check("t2_no_bypass", rt_valid, 0);
        step();
        pe_valid = 1'b0;
        check("t2_valid", rt_valid, 1);
        check("t2_flit", rt_flit, 20'hA1234);
        check("t2_occ1", occupancy, 1);
        step();
        check("t2_valid_drop", rt_valid, 0);
        check("t2_occ0", occupancy, 0);
        check("t2_flit0", rt_flit, 0);
        check("t2_count", rx_q.size(), 1);
        check("t2_rx", rx_q[0], 20'hA1234);

        // fresh credits for T3
        rst = 1'b0;
        #1;
        check("rst_async_occ", occupancy, 0);
        rst = 1'b1;
        rx_q.delete();

        // T3 six flits, no credits returned
        for (int i = 0; i < 6; i++) begin
            pe_flit  = f3[i];
            pe_valid = 1'b1;
            check($sformatf("t3_ready%0d", i), pe_ready, 1);
            step();
        end
        pe_valid = 1'b0;
        check("t3_sent", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_order%0d", i), rx_q[i], f3[i]);
        check("t3_valid", rt_valid, 0);
        check("t3_occ", occupancy, 2);
        check("t3_ready", pe_ready, 1);

        // T4 two credits release the remaining two
        rt_credit = 1'b1;
        step();
        rt_credit = 1'b0;
        check("t4_valid_a", rt_valid, 1);
        check("t4_flit_a", rt_flit, f3[4]);
        step();
        check("t4_stall", rt_valid, 0);
        check("t4_occ1", occupancy, 1);
        rt_credit = 1'b1;
        step();
        rt_credit = 1'b0;
        check("t4_valid_b", rt_valid, 1);
        check("t4_flit_b", rt_flit, f3[5]);
        step();
        check("t4_occ0", occupancy, 0);
        check("t4_sent", rx_q.size(), 6);
        for (int i = 4; i < 6; i++) check($sformatf("t4_order%0d", i), rx_q[i], f3[i]);
`ifdef NI_STATS_EN
        check("t7_sent", stat_sent, 6);
        check("t7_stall", stat_stall, 3);
`endif

        // T5 fill with credits at zero
        for (int i = 0; i < 4; i++) begin
            pe_flit  = g5[i];
            pe_valid = 1'b1;
            step();
        end
        check("t5_full_occ", occupancy, 4);
        check("t5_full_ready", pe_ready, 0);
        check("t5_full_valid", rt_valid, 0);
        pe_flit = g5[4];
        step();
        step();
        check("t5_hold_occ", occupancy, 4);
        check("t5_hold_ready", pe_ready, 0);
        rt_credit = 1'b1;
        step();
        rt_credit = 1'b0;
        check("t5_send_valid", rt_valid, 1);
        check("t5_send_flit", rt_flit, g5[0]);
        step();
        check("t5_ready_back", pe_ready, 1);
        check("t5_occ3", occupancy, 3);
        step();
        pe_valid = 1'b0;
        check("t5_occ_refill", occupancy, 4);
        for (int i = 0; i < 4; i++) begin
            rt_credit = 1'b1;
            step();
            rt_credit = 1'b0;
            step();
        end
        check("t5_drained", occupancy, 0);
        check("t5_sent", rx_q.size(), 11);
        for (int i = 0; i < 5; i++) check($sformatf("t5_order%0d", i), rx_q[6+i], g5[i]);

        // T6 credit accounting and sticky error
        rt_credit = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rt_credit = 1'b0;
        check("t6_err_clear", cred_err, 0);
        pe_flit  = 20'h9C3C3;
        pe_valid = 1'b1;
        step();
        pe_valid  = 1'b0;
        check("t6_valid", rt_valid, 1);
        rt_credit = 1'b1;
        step();
        rt_credit = 1'b0;
        check("t6_send_cred_err", cred_err, 0);
        check("t6_send_cred_occ", occupancy, 0);
        check("t6_rx", rx_q[11], 20'h9C3C3);
        rt_credit = 1'b1;
        step();
        rt_credit = 1'b0;
        check("t6_err_set", cred_err, 1);
        step();
        step();
        step();
        check("t6_err_sticky", cred_err, 1);

        // reset mid-traffic discards queue and restores credits
        for (int i = 0; i < 6; i++) begin
            pe_flit  = 20'h70000 + 20'(i);
            pe_valid = 1'b1;
            step();
        end
        pe_valid = 1'b0;
        check("rm_occ_before", occupancy, 2);
        rst = 1'b0;
        #1;
        check("rm_occ", occupancy, 0);
        check("rm_valid", rt_valid, 0);
        check("rm_err", cred_err, 0);
        check("rm_ready", pe_ready, 1);
        check("rm_flit", rt_flit, 0);
        rst = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 5; i++) begin
            pe_flit  = 20'hE0000 + 20'(i);
            pe_valid = 1'b1;
            step();
        end
        pe_valid = 1'b0;
        step();
        step();
        check("rm_sent", rx_q.size(), 4);
        check("rm_first", rx_q[0], 20'hE0000);
        check("rm_last", rx_q[3], 20'hE0003);
        check("rm_occ_left", occupancy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
